mid_line_buf: RTL and testbench

- Parametrised multi-bank row buffer between conv stages.
- Stores consecutive incoming feature-map rows round-robin into NUM_BANKS single-port-style memories.
- Tracks row/frame position; exposes all banks in parallel for a downstream KxK window engine.
- Generalises fixed 4-bank/63-bit/28x28 design; adds row-complete status, overflow detection and all-posedge timing.

---
 rtl/mid_line_buf.sv | 167 ++++++++++++++++
 tb/tb_mid_line_buf.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mid_line_buf.sv
// mid_line_buf: multi-bank row buffer between conv stages.
// Incoming rows are written round-robin into NUM_BANKS row memories, and every
// bank is read in parallel at a single address for a downstream KxK window engine.
// Build option: define MID_LINE_BUF_ROTATE_EN so that q lane 0 carries the oldest
// held row and lane NUM_BANKS-1 the newest. Without it, lane i always maps to bank i.
module mid_line_buf #(
  parameter int DATA_W    = 63,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W    = 5,
  parameter int CNT_W     = 12
) (
  input  logic                          clk,
  input  logic                          RESET,
  input  logic                          start_wr,
  input  logic                          de_in,
  input  logic [DATA_W-1:0]             din,
  input  logic                          rd_en,
  input  logic [ADDR_W-1:0]             rd_addr,
  output logic [NUM_BANKS*DATA_W-1:0]   q,
  output logic                          q_valid,
  output logic [$clog2(NUM_BANKS)-1:0]  wr_bank,
  output logic [CNT_W-1:0]              row_cnt,
  output logic [$clog2(NUM_BANKS):0]    rows_avail,
  output logic                          row_done,
  output logic                          frame_done,
  output logic                          ovf
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int RA_W   = BANK_W + 1;
  // One extra bit so the write pointer can sit at IMG_W and flag overflow.
  localparam int WA_W   = ADDR_W + 1;

  localparam logic [WA_W-1:0]   IMG_W_L    = WA_W'(IMG_W);
  localparam logic [CNT_W-1:0]  LAST_ROW   = CNT_W'(IMG_H - 1);
  localparam logic [BANK_W-1:0] LAST_BANK  = BANK_W'(NUM_BANKS - 1);
  localparam logic [RA_W-1:0]   FULL_AVAIL = RA_W'(NUM_BANKS);

  logic [WA_W-1:0]   wr_addr_q,    wr_addr_d;
  logic              de_d_q,       de_d_d;
  logic [BANK_W-1:0] wr_bank_q,    wr_bank_d;
  logic [CNT_W-1:0]  row_cnt_q,    row_cnt_d;
  logic [RA_W-1:0]   rows_avail_q, rows_avail_d;
  logic              row_done_q,   row_done_d;
  logic              frame_done_q, frame_done_d;
  logic              ovf_q,        ovf_d;
  logic              wr_en;

  logic [DATA_W-1:0]           mem_q [NUM_BANKS][IMG_W];
  logic [NUM_BANKS*DATA_W-1:0] rd_data;
  logic [BANK_W-1:0]           src;
  logic [NUM_BANKS*DATA_W-1:0] q_q;
  logic                        q_valid_q;

  // Write pointer, row/frame tracking and overflow detection (next state).
  always_comb begin
    wr_addr_d    = wr_addr_q;
    de_d_d       = de_in;
    wr_bank_d    = wr_bank_q;
    row_cnt_d    = row_cnt_q;
    rows_avail_d = rows_avail_q;
    row_done_d   = 1'b0;
    frame_done_d = 1'b0;
    ovf_d        = ovf_q;
    wr_en        = 1'b0;
    if (start_wr) begin
      // Frame restart wins over a coincident row end; memory and ovf are kept.
      wr_addr_d    = '0;
      de_d_d       = 1'b0;
      wr_bank_d    = '0;
      row_cnt_d    = '0;
      rows_avail_d = '0;
    end else if (de_in) begin
      if (wr_addr_q < IMG_W_L) begin
        wr_en     = 1'b1;
        wr_addr_d = wr_addr_q + WA_W'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end else if (de_d_q) begin
      wr_addr_d  = '0;
      row_done_d = 1'b1;
      if (row_cnt_q == LAST_ROW) begin
        row_cnt_d    = '0;
        wr_bank_d    = '0;
        rows_avail_d = '0;
        frame_done_d = 1'b1;
      end else begin
        row_cnt_d    = row_cnt_q + CNT_W'(1);
        wr_bank_d    = (wr_bank_q == LAST_BANK) ? '0 : wr_bank_q + BANK_W'(1);
        rows_avail_d = (rows_avail_q == FULL_AVAIL) ? rows_avail_q
                                                    : rows_avail_q + RA_W'(1);
      end
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (RESET) begin
      wr_addr_q    <= '0;
      de_d_q       <= 1'b0;
      wr_bank_q    <= '0;
      row_cnt_q    <= '0;
      rows_avail_q <= '0;
      row_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      wr_addr_q    <= wr_addr_d;
      de_d_q       <= de_d_d;
      wr_bank_q    <= wr_bank_d;
      row_cnt_q    <= row_cnt_d;
      rows_avail_q <= rows_avail_d;
      row_done_q   <= row_done_d;
      frame_done_q <= frame_done_d;
      ovf_q        <= ovf_d;
    end
  end

  // Row memories: one write port into the active bank, contents survive resets.
  always_ff @(posedge clk) begin
    if (wr_en && !RESET) begin
      mem_q[wr_bank_q][wr_addr_q[ADDR_W-1:0]] <= din;
    end
  end

  // Parallel read mux across all banks; out-of-range addresses return zero.
  always_comb begin
    rd_data = '0;
    src     = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
`ifdef MID_LINE_BUF_ROTATE_EN
      src = BANK_W'((32'(wr_bank_q) + i) % NUM_BANKS);
`else
      src = BANK_W'(i);
`endif
      if ({1'b0, rd_addr} < IMG_W_L) begin
        rd_data[i*DATA_W +: DATA_W] = mem_q[src][rd_addr];
      end
    end
  end

  // Registered read data; sampling before the same-edge write gives read-first.
  always_ff @(posedge clk) begin
    if (RESET || start_wr) begin
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      q_valid_q <= rd_en;
      if (rd_en) begin
        q_q <= rd_data;
      end
    end
  end

  assign q          = q_q;
  assign q_valid    = q_valid_q;
  assign wr_bank    = wr_bank_q;
  assign row_cnt    = row_cnt_q;
  assign rows_avail = rows_avail_q;
  assign row_done   = row_done_q;
  assign frame_done = frame_done_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_mid_line_buf.sv
// Self-checking bench for mid_line_buf with a behavioural row-buffer model.
module tb_mid_line_buf;

  localparam int DW  = 63;
  localparam int IW  = 28;
  localparam int IH  = 28;
  localparam int NB  = 4;
  localparam int AW  = 5;
  localparam int CW  = 12;
  localparam int BW  = 2;
  localparam int RAW = BW + 1;
`ifdef MID_LINE_BUF_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              RESET, start_wr, de_in, rd_en;
  logic [DW-1:0]     din;
  logic [AW-1:0]     rd_addr;
  logic [NB*DW-1:0]  q;
  logic              q_valid;
  logic [BW-1:0]     wr_bank;
  logic [CW-1:0]     row_cnt;
  logic [RAW-1:0]    rows_avail;
  logic              row_done, frame_done, ovf;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: rows completed in the frame, words in the current row.
  logic [DW-1:0] m_mem [NB][IW];
  bit            m_wk  [NB][IW];
  logic [DW-1:0] m_q   [NB];
  bit            m_qk  [NB];
  bit            m_qv, m_rowd, m_fd, m_ovf, m_de_prev;
  int            m_words, m_rows;

  mid_line_buf #(
    .DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .NUM_BANKS(NB), .ADDR_W(AW), .CNT_W(CW)
  ) dut (
    .clk(clk), .RESET(RESET), .start_wr(start_wr), .de_in(de_in), .din(din),
    .rd_en(rd_en), .rd_addr(rd_addr), .q(q), .q_valid(q_valid), .wr_bank(wr_bank),
    .row_cnt(row_cnt), .rows_avail(rows_avail), .row_done(row_done),
    .frame_done(frame_done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] lane(input int i);
    return q[i*DW +: DW];
  endfunction

  // Lane on which a given bank appears when the write bank was wb at read time.
  function automatic int lane_of(input int bank, input int wb);
    return ROT ? (bank - wb + NB) % NB : bank;
  endfunction

  function automatic logic [DW-1:0] rnd();
    return DW'({$urandom(), $urandom()});
  endfunction

  function automatic int exp_avail();
    return (m_rows < NB) ? m_rows : NB;
  endfunction

  // Drive one cycle of inputs and advance the model across that clock edge.
  task automatic step(input bit rst, input bit st, input bit de, input logic [DW-1:0] d,
                      input bit rd, input logic [AW-1:0] ra);
    int b;
    RESET = rst; start_wr = st; de_in = de; din = d; rd_en = rd; rd_addr = ra;
    @(posedge clk);
    if (rst || st) begin
      if (rst) m_ovf = 1'b0;
      m_words = 0; m_rows = 0; m_de_prev = 1'b0;
      m_rowd = 1'b0; m_fd = 1'b0; m_qv = 1'b0;
      for (int i = 0; i < NB; i++) begin m_q[i] = '0; m_qk[i] = 1'b1; end
    end else begin
      m_qv = rd;
      if (rd) begin
        for (int i = 0; i < NB; i++) begin
          b = ROT ? ((m_rows % NB) + i) % NB : i;
          if (int'(ra) < IW && m_wk[b][int'(ra)]) begin
            m_q[i] = m_mem[b][int'(ra)]; m_qk[i] = 1'b1;
          end else begin
            m_qk[i] = 1'b0;
          end
        end
      end
      m_rowd = 1'b0; m_fd = 1'b0;
      if (de) begin
        if (m_words < IW) begin
          m_mem[m_rows % NB][m_words] = d;
          m_wk[m_rows % NB][m_words]  = 1'b1;
          m_words++;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (m_de_prev) begin
        m_words = 0; m_rowd = 1'b1; m_rows++;
        if (m_rows == IH) begin m_rows = 0; m_fd = 1'b1; end
      end
      m_de_prev = de;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [DW-1:0] first;
    step(1, 0, 0, '0, 0, '0);
    step(1, 0, 0, '0, 0, '0);
    for (int k = 0; k < 5; k++) step(0, 0, 1, rnd(), 0, '0);
    step(0, 0, 1, rnd(), 1, 5'd2);
    step(1, 0, 1, rnd(), 1, '0);
    step(1, 0, 1, rnd(), 1, '0);
    n_cmp++;
    if ({q_valid, wr_bank, row_cnt, rows_avail, row_done, frame_done, ovf} !== '0) begin
      n_err++;
      $display("FAIL reset_ctrl: got qv=%b bank=%0d cnt=%0d avail=%0d rd=%b fd=%b ovf=%b want all 0",
               q_valid, wr_bank, row_cnt, rows_avail, row_done, frame_done, ovf);
    end
    n_cmp++;
    if (q !== '0) begin n_err++; $display("FAIL reset_q: got %h want 0", q); end
    first = rnd();
    step(0, 0, 1, first, 0, '0);
    for (int k = 1; k < IW; k++) step(0, 0, 1, rnd(), 0, '0);
    step(0, 0, 0, '0, 0, '0);
    n_cmp++;
    if (row_done !== 1'b1 || wr_bank !== BW'(1)) begin
      n_err++; $display("FAIL reset_row_end: got rd=%b bank=%0d want rd=1 bank=1", row_done, wr_bank);
    end
    step(0, 0, 0, '0, 1, '0);
    n_cmp++;
    if (lane(lane_of(0, 1)) !== first) begin
      n_err++; $display("FAIL reset_first_word: got %h want %h", lane(lane_of(0, 1)), first);
    end
  endtask

  task automatic test_single_row();
    step(1, 0, 0, '0, 0, '0);
    step(1, 0, 0, '0, 0, '0);
    for (int a = 0; a < IW; a++) step(0, 0, 1, DW'(a + 100), 0, '0);
    n_cmp++;
    if (row_done !== 1'b0) begin n_err++; $display("FAIL single_early_done: got %b want 0", row_done); end
    step(0, 0, 0, '0, 0, '0);
    n_cmp++;
    if (row_done !== 1'b1 || wr_bank !== BW'(1) || rows_avail !== RAW'(1) || q_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_row_end: got rd=%b bank=%0d avail=%0d qv=%b want 1/1/1/0",
               row_done, wr_bank, rows_avail, q_valid);
    end
    step(0, 0, 0, '0, 1, 5'd5);
    n_cmp++;
    if (row_done !== 1'b0 || q_valid !== 1'b1) begin
      n_err++; $display("FAIL single_read_valid: got rd=%b qv=%b want 0/1", row_done, q_valid);
    end
    n_cmp++;
    if (lane(lane_of(0, 1)) !== DW'(105)) begin
      n_err++; $display("FAIL single_read_data: got %0d want 105", lane(lane_of(0, 1)));
    end
    step(0, 0, 0, '0, 0, 5'd9);
    n_cmp++;
    if (q_valid !== 1'b0 || lane(lane_of(0, 1)) !== DW'(105)) begin
      n_err++; $display("FAIL single_hold: got qv=%b data=%0d want 0/105", q_valid, lane(lane_of(0, 1)));
    end
  endtask

  task automatic test_full_frame();
    int nrd = 0, nfd = 0, bad = 0, ea;
    step(1, 0, 0, '0, 0, '0);
    for (int r = 0; r < IH; r++) begin
      for (int a = 0; a < IW; a++) begin
        step(0, 0, 1, rnd(), 0, '0);
        if (row_done) nrd++;
        if (frame_done) nfd++;
      end
      for (int g = 0; g < 4; g++) begin
        step(0, 0, 0, '0, 0, '0);
        if (row_done) nrd++;
        if (frame_done) begin nfd++; if (!row_done || r != IH - 1) bad++; end
        if (g == 0) begin
          ea = (r == IH - 1) ? 0 : ((r + 1 < NB) ? r + 1 : NB);
          n_cmp++;
          if (rows_avail !== RAW'(ea) || row_cnt !== CW'((r + 1) % IH)) begin
            n_err++;
            $display("FAIL frame_row%0d: got avail=%0d cnt=%0d want avail=%0d cnt=%0d",
                     r, rows_avail, row_cnt, ea, (r + 1) % IH);
          end
        end
      end
    end
    n_cmp++;
    if (nrd != IH || nfd != 1 || bad != 0) begin
      n_err++; $display("FAIL frame_pulses: got row_done=%0d frame_done=%0d misplaced=%0d want %0d/1/0",
                        nrd, nfd, bad, IH);
    end
    n_cmp++;
    if (row_cnt !== '0 || wr_bank !== '0 || rows_avail !== '0) begin
      n_err++; $display("FAIL frame_wrap: got cnt=%0d bank=%0d avail=%0d want 0/0/0", row_cnt, wr_bank, rows_avail);
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] w [30];
    step(1, 0, 0, '0, 0, '0);
    for (int k = 0; k < 30; k++) begin
      w[k] = rnd();
      step(0, 0, 1, w[k], 0, '0);
      if (k == 27) begin
        n_cmp++;
        if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b want 0", ovf); end
      end
      if (k == 28) begin
        n_cmp++;
        if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", ovf); end
      end
    end
    step(0, 0, 0, '0, 0, '0);
    step(0, 0, 0, '0, 0, '0);
    for (int a = 0; a < IW; a++) begin
      step(0, 0, 0, '0, 1, AW'(a));
      n_cmp++;
      if (lane(lane_of(0, 1)) !== w[a]) begin
        n_err++; $display("FAIL ovf_data_a%0d: got %h want %h", a, lane(lane_of(0, 1)), w[a]);
      end
    end
    step(0, 1, 0, '0, 0, '0);
    n_cmp++;
    if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
    step(1, 0, 0, '0, 0, '0);
    n_cmp++;
    if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_reset: got %b want 0", ovf); end
  endtask

  task automatic test_collision();
    step(1, 0, 0, '0, 0, '0);
    for (int a = 0; a < IW; a++) step(0, 0, 1, DW'('h55), 0, '0);
    step(0, 0, 0, '0, 0, '0);
    step(0, 1, 0, '0, 0, '0);
    for (int a = 0; a < IW; a++) begin
      step(0, 0, 1, (a == 3) ? DW'('hAA) : DW'('h77), (a == 3), 5'd3);
      if (a == 3) begin
        n_cmp++;
        if (lane(lane_of(0, 0)) !== DW'('h55)) begin
          n_err++; $display("FAIL collision_old: got %h want 55", lane(lane_of(0, 0)));
        end
      end
    end
    step(0, 0, 0, '0, 0, '0);
    step(0, 0, 0, '0, 1, 5'd3);
    n_cmp++;
    if (lane(lane_of(0, 1)) !== DW'('hAA)) begin
      n_err++; $display("FAIL collision_new: got %h want aa", lane(lane_of(0, 1)));
    end
  endtask

  task automatic test_rotate();
    logic [DW-1:0] rw [5];
    step(1, 0, 0, '0, 0, '0);
    for (int r = 0; r < 5; r++) begin
      rw[r] = rnd();
      step(0, 0, 1, rw[r], 0, '0);
      for (int a = 1; a < IW; a++) step(0, 0, 1, rnd(), 0, '0);
      step(0, 0, 0, '0, 0, '0);
      step(0, 0, 0, '0, 0, '0);
    end
    n_cmp++;
    if (wr_bank !== BW'(1)) begin n_err++; $display("FAIL rotate_bank: got %0d want 1", wr_bank); end
    step(0, 0, 0, '0, 1, '0);
    n_cmp++;
    if (ROT ? (lane(0) !== rw[1] || lane(3) !== rw[4]) : (lane(0) !== rw[4] || lane(1) !== rw[1])) begin
      n_err++; $display("FAIL rotate_lanes: got l0=%h l1=%h l3=%h (row1=%h row4=%h rotate=%b)",
                        lane(0), lane(1), lane(3), rw[1], rw[4], ROT);
    end
  endtask

  task automatic test_random();
    int rem = 0;
    bit rst, st, de, rd;
    step(1, 0, 0, '0, 0, '0);
    for (int c = 0; c < 700; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      st  = ($urandom_range(0, 59) == 0);
      if (rem > 0) begin de = 1'b1; rem--; end
      else begin de = 1'b0; if ($urandom_range(0, 2) == 0) rem = $urandom_range(1, 31); end
      rd = $urandom_range(0, 1) == 1;
      step(rst, st, de, rnd(), rd, AW'($urandom_range(0, 31)));
      n_cmp++;
      if (wr_bank !== BW'(m_rows % NB) || row_cnt !== CW'(m_rows) || rows_avail !== RAW'(exp_avail())) begin
        n_err++; $display("FAIL rand_ctrl c%0d: got bank=%0d cnt=%0d avail=%0d want %0d/%0d/%0d",
                          c, wr_bank, row_cnt, rows_avail, m_rows % NB, m_rows, exp_avail());
      end
      n_cmp++;
      if (row_done !== m_rowd || frame_done !== m_fd || ovf !== m_ovf || q_valid !== m_qv) begin
        n_err++; $display("FAIL rand_flags c%0d: got rd=%b fd=%b ovf=%b qv=%b want %b/%b/%b/%b",
                          c, row_done, frame_done, ovf, q_valid, m_rowd, m_fd, m_ovf, m_qv);
      end
      for (int i = 0; i < NB; i++) begin
        if (m_qk[i]) begin
          n_cmp++;
          if (lane(i) !== m_q[i]) begin
            n_err++; $display("FAIL rand_q c%0d lane%0d: got %h want %h", c, i, lane(i), m_q[i]);
          end
        end
      end
    end
  endtask

  initial begin
    RESET = 1'b1; start_wr = 1'b0; de_in = 1'b0; din = '0; rd_en = 1'b0; rd_addr = '0;
    test_reset();
    test_single_row();
    test_full_frame();
    test_overflow();
    test_collision();
    test_rotate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
